bit_addr: RTL and testbench

BIT_ADDR -- requirements
Module: bit_addr

---
 rtl/bit_addr_pkg.sv | 19 +
 rtl/bit_addr_fa_cell.sv | 18 +
 rtl/bit_addr.sv | 102 ++++++++++
 tb/tb_bit_addr.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bit_addr_pkg.sv
// Shared constants, full-adder result type and evaluation function for bit_addr.
package bit_addr_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

  typedef struct packed {
    logic sum;
    logic carry;
  } fa_res_t;

  function automatic fa_res_t fa_eval(input logic a, input logic b, input logic ci);
    fa_res_t r;
    r.sum   = a ^ b ^ ci;
    r.carry = (a & b) | (ci & (a ^ b));
    return r;
  endfunction

endpackage

// File: rtl/bit_addr_fa_cell.sv
// One-bit full adder cell; shared by the combinational port path and the serial engine.
module fa_cell
  import bit_addr_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  fa_res_t res;

  assign res = fa_eval(a, b, ci);
  assign s   = res.sum;
  assign co  = res.carry;

endmodule

// File: rtl/bit_addr.sv
// Full adder with an optional LSB-first bit-serial adder of WIDTH bits.
// The serial engine is compiled in only when BIT_ADDR_SERIAL_EN is defined.
module bit_addr
  import bit_addr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  output logic             Sum,
  output logic             cout,
  input  logic             ser_start,
  input  logic             ser_valid,
  output logic             ser_busy,
  output logic             ser_done,
  output logic [WIDTH-1:0] ser_sum,
  output logic             ser_cout
);

  // Zero-latency path, deliberately outside any reset domain.
  fa_cell u_fa_comb (
    .a  (a),
    .b  (b),
    .ci (cin),
    .s  (Sum),
    .co (cout)
  );

`ifdef BIT_ADDR_SERIAL_EN

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             s_ser;
  logic             c_ser;

  fa_cell u_fa_ser (
    .a  (a),
    .b  (b),
    .ci (carry_q),
    .s  (s_ser),
    .co (c_ser)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        // A start beat is never consumed, even with ser_valid high.
        if (ser_start) begin
          carry_q <= cin;
          cnt_q   <= '0;
          sum_q   <= '0;
          busy_q  <= 1'b1;
        end
      end else if (ser_valid) begin
        sum_q   <= {s_ser, sum_q[WIDTH-1:1]};
        carry_q <= c_ser;
        cnt_q   <= cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          busy_q <= 1'b0;
          cout_q <= c_ser;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign ser_busy = busy_q;
  assign ser_done = done_q;
  assign ser_sum  = sum_q;
  assign ser_cout = cout_q;

`else

  logic unused_ser;
  assign unused_ser = ^{clk, rst_n, ser_start, ser_valid};

  assign ser_busy = 1'b0;
  assign ser_done = 1'b0;
  assign ser_sum  = '0;
  assign ser_cout = 1'b0;

`endif

endmodule

// File: tb/tb_bit_addr.sv
// Self-checking bench for bit_addr: table-driven full-adder vectors plus
// directed and randomized serial additions checked against integer arithmetic.
module tb_bit_addr;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         a = 1'b0, b = 1'b0, cin = 1'b0;
  logic         Sum, cout;
  logic         ser_start = 1'b0, ser_valid = 1'b0;
  logic         ser_busy, ser_done, ser_cout;
  logic [W-1:0] ser_sum;

  int checks = 0;
  int errors = 0;

  bit_addr #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .Sum       (Sum),
    .cout      (cout),
    .ser_start (ser_start),
    .ser_valid (ser_valid),
    .ser_busy  (ser_busy),
    .ser_done  (ser_done),
    .ser_sum   (ser_sum),
    .ser_cout  (ser_cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic a, b, c;
    logic s, co;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: the full adder is just a 2-bit integer sum.
  task automatic chk_comb(input string name);
    int t;
    t = int'(a) + int'(b) + int'(cin);
    chk({name, "_sum"},  {31'd0, Sum},  t % 2);
    chk({name, "_cout"}, {31'd0, cout}, t / 2);
  endtask

`ifdef BIT_ADDR_SERIAL_EN
  // gap: 0 none, 1 idle cycle before every other beat, 2 random idles.
  task automatic run_serial(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                            input int gap, input bit mid_start, input bit start_valid,
                            input string name);
    int           total;
    logic [W-1:0] exp_sum;
    logic         exp_co;
    int           dones;
    total   = int'(x) + int'(y) + int'(c);
    exp_sum = W'(total);
    exp_co  = (total >> W) & 1;
    dones   = 0;
    @(negedge clk);
    ser_start = 1'b1; cin = c;
    ser_valid = start_valid; a = 1'b1; b = 1'b1;
    @(negedge clk);
    ser_start = 1'b0; ser_valid = 1'b0;
    chk({name, "_busy_after_start"}, {31'd0, ser_busy}, 1);
    for (int i = 0; i < W; i++) begin
      int idles;
      idles = (gap == 1) ? (i % 2) : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int k = 0; k < idles; k++) begin
        ser_valid = 1'b0; a = 1'($urandom); b = 1'($urandom);
        @(negedge clk);
        if (ser_done) dones++;
      end
      a = x[i]; b = y[i]; ser_valid = 1'b1;
      if (mid_start && i == 3) begin
        ser_start = 1'b1; cin = ~c;
      end
      @(negedge clk);
      ser_start = 1'b0;
      if (i < W - 1 && ser_done) dones++;
    end
    ser_valid = 1'b0;
    chk({name, "_done"}, {31'd0, ser_done}, 1);
    chk({name, "_early_done"}, dones, 0);
    chk({name, "_busy_end"}, {31'd0, ser_busy}, 0);
    chk({name, "_sum"}, {24'd0, ser_sum}, {24'd0, exp_sum});
    chk({name, "_cout"}, {31'd0, ser_cout}, {31'd0, exp_co});
    a = 1'($urandom); b = 1'($urandom); ser_valid = 1'b1;
    @(negedge clk);
    ser_valid = 1'b0;
    chk({name, "_done_one_cycle"}, {31'd0, ser_done}, 0);
    chk({name, "_sum_hold"}, {24'd0, ser_sum}, {24'd0, exp_sum});
    chk({name, "_cout_hold"}, {31'd0, ser_cout}, {31'd0, exp_co});
  endtask
`endif

  vec_t vecs[8];

  initial begin
    vecs[0] = '{a:0, b:1, c:0, s:1, co:0};
    vecs[1] = '{a:1, b:1, c:0, s:0, co:1};
    vecs[2] = '{a:1, b:1, c:1, s:1, co:1};
    vecs[3] = '{a:1, b:0, c:0, s:1, co:0};
    vecs[4] = '{a:0, b:1, c:1, s:0, co:1};
    vecs[5] = '{a:0, b:0, c:0, s:0, co:0};
    vecs[6] = '{a:0, b:0, c:1, s:1, co:0};
    vecs[7] = '{a:1, b:0, c:1, s:0, co:1};

    // Combinational path must work while still in reset.
    #2;
    chk("rst_busy", {31'd0, ser_busy}, 0);
    chk("rst_done", {31'd0, ser_done}, 0);
    chk("rst_sum",  {24'd0, ser_sum}, 0);
    chk("rst_cout", {31'd0, ser_cout}, 0);
    for (int i = 0; i < 8; i++) begin
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].c;
      #1;
      chk($sformatf("vec%0d_sum", i),  {31'd0, Sum},  {31'd0, vecs[i].s});
      chk($sformatf("vec%0d_cout", i), {31'd0, cout}, {31'd0, vecs[i].co});
      if (i == 1) rst_n = 1'b1;
      #59;
    end

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a = 1'($urandom); b = 1'($urandom); cin = 1'($urandom);
      #1;
      chk($sformatf("rnd_comb%0d", i), {29'd0, Sum, cout, 1'b0},
          {29'd0, 1'((int'(a) + int'(b) + int'(cin)) % 2), 1'((int'(a) + int'(b) + int'(cin)) / 2), 1'b0});
    end

`ifdef BIT_ADDR_SERIAL_EN
    run_serial(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0, "ff_p_01");
    run_serial(8'h5A, 8'h25, 1'b1, 1, 1'b0, 1'b0, "5a_p_25_gap");
    chk("5a_p_25_const", {24'd0, ser_sum}, 32'h80);
    run_serial(8'h5A, 8'h25, 1'b1, 0, 1'b1, 1'b0, "start_while_busy");
    run_serial(8'h3C, 8'hC3, 1'b1, 0, 1'b0, 1'b1, "start_with_valid");
    for (int r = 0; r < 20; r++)
      run_serial(W'($urandom), W'($urandom), 1'($urandom), 2, r[0], r[1],
                 $sformatf("rnd_ser%0d", r));

    // Abort after 3 beats: partial sum is nonzero, so a cleared word proves the reset.
    @(negedge clk);
    ser_start = 1'b1; cin = 1'b0;
    @(negedge clk);
    ser_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 1'b1; b = 1'b0; ser_valid = 1'b1;
      @(negedge clk);
    end
    chk("pre_abort_sum", {24'd0, ser_sum}, 32'hE0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, ser_busy}, 0);
    chk("abort_sum",  {24'd0, ser_sum}, 0);
    chk("abort_cout", {31'd0, ser_cout}, 0);
    chk("abort_done", {31'd0, ser_done}, 0);
    a = 1'b1; b = 1'b1; cin = 1'b1;
    #1;
    chk_comb("abort_comb_a");
    a = 1'b0; cin = 1'b0;
    #1;
    chk_comb("abort_comb_b");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = 1'($urandom); b = 1'($urandom); ser_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("post_abort%0d", i), {30'd0, ser_done, ser_busy}, 0);
    end
    ser_valid = 1'b0;
    run_serial(8'h80, 8'h80, 1'b1, 0, 1'b0, 1'b0, "after_abort");
`else
    // Without the serial engine the serial outputs must stay tied low.
    for (int i = 0; i < 12; i++) begin
      ser_start = 1'($urandom); ser_valid = 1'($urandom);
      a = 1'($urandom); b = 1'($urandom); cin = 1'($urandom);
      @(negedge clk);
      chk($sformatf("tied%0d", i), {22'd0, ser_busy, ser_done, ser_sum},  0);
      chk($sformatf("tied_cout%0d", i), {31'd0, ser_cout}, 0);
      chk_comb($sformatf("tied_comb%0d", i));
    end
    ser_start = 1'b0; ser_valid = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
